// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: takes one decoded access, runs a valid/ready request on the
// 64-bit data bus, then returns extended load data or a fault as a one-cycle pulse.
module lsu_mem_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [4:0]  rd_idx,
    input  logic        flush,
    output logic        busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [7:0]  mem_req_be,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        done,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        fault_valid,
    output logic [1:0]  fault_cause,
    output logic [63:0] fault_addr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] C_MISALIGN = 2'b00;
    localparam logic [1:0] C_ILLEGAL  = 2'b01;
    localparam logic [1:0] C_BUSERR   = 2'b10;
    localparam logic [1:0] C_TIMEOUT  = 2'b11;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_rd_ctrl, r_wr_ctrl;
    logic [63:0] r_addr, r_wdata;
    logic [4:0]  r_rd_idx;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_flushed, w_flushed_nxt;
    logic        r_done, w_done_nxt;
    logic        r_wb_valid, w_wb_nxt;
    logic [4:0]  r_wb_rd;
    logic [63:0] r_wb_data, w_wb_data_nxt;
    logic        r_fault, w_fault_nxt;
    logic [1:0]  r_fault_cause, w_cause_nxt;
    logic [63:0] r_fault_addr, w_faddr_nxt;

    logic        w_idle, w_req, w_issue, w_latch, w_illegal, w_misal, w_discard;

    function automatic logic [63:0] load_extend(input logic [2:0] code, input logic [2:0] off,
                                                input logic [63:0] rdata);
        logic [63:0] s;
        s = rdata >> {off, 3'b000};
        case (code)
            3'b001:  return {{56{s[7]}}, s[7:0]};
            3'b010:  return {56'b0, s[7:0]};
            3'b011:  return {{48{s[15]}}, s[15:0]};
            3'b100:  return {48'b0, s[15:0]};
            3'b101:  return {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [7:0] store_be(input logic [2:0] code, input logic [2:0] off);
        case (code)
            3'b001:  return 8'h01 << off;
            3'b010:  return 8'h03 << off;
            3'b011:  return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] store_lanes(input logic [2:0] code, input logic [63:0] d);
        case (code)
            3'b001:  return {8{d[7:0]}};
            3'b010:  return {4{d[15:0]}};
            3'b011:  return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    assign w_idle  = (r_state == S_IDLE);
    assign w_req   = (r_state == S_REQ);
    assign w_issue = issue_valid & w_idle & ~flush & ((dm_rd_ctrl != 3'b000) | (dm_wr_ctrl != 3'b000));

    assign w_illegal = ((dm_rd_ctrl != 3'b000) && (dm_wr_ctrl != 3'b000)) ||
                       (dm_rd_ctrl == 3'b111) || (dm_wr_ctrl >= 3'd5);

    always_comb begin
        w_misal = 1'b0;
        case (dm_rd_ctrl)
            3'b011, 3'b100: w_misal = addr[0];
            3'b101:         w_misal = |addr[1:0];
            3'b110:         w_misal = |addr[2:0];
            default:        ;
        endcase
        case (dm_wr_ctrl)
            3'b010:  w_misal = w_misal | addr[0];
            3'b011:  w_misal = w_misal | (|addr[1:0]);
            3'b100:  w_misal = w_misal | (|addr[2:0]);
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flushed_nxt = r_flushed;
        w_latch       = 1'b0;
        w_discard     = 1'b0;
        w_done_nxt    = 1'b0;
        w_wb_nxt      = 1'b0;
        w_wb_data_nxt = r_wb_data;
        w_fault_nxt   = 1'b0;
        w_cause_nxt   = r_fault_cause;
        w_faddr_nxt   = r_fault_addr;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_latch = 1'b1;
                    if (w_illegal || w_misal) begin
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = w_illegal ? C_ILLEGAL : C_MISALIGN;
                        w_faddr_nxt = addr;
                    end else begin
                        w_state_nxt   = S_REQ;
                        w_flushed_nxt = 1'b0;
                    end
                end
            end
            S_REQ: begin
                // Once the bus has taken the request the response must still be drained.
                if (mem_req_ready) begin
                    w_state_nxt   = S_RSP;
                    w_cnt_nxt     = 8'd0;
                    w_flushed_nxt = flush;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RSP: begin
                w_discard     = r_flushed | flush;
                w_flushed_nxt = w_discard;
                if (mem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                    if (!w_discard) begin
                        if (mem_rsp_err) begin
                            w_fault_nxt = 1'b1;
                            w_cause_nxt = C_BUSERR;
                            w_faddr_nxt = r_addr;
                        end else begin
                            w_done_nxt = 1'b1;
                            if (r_rd_ctrl != 3'b000) begin
                                w_wb_nxt      = 1'b1;
                                w_wb_data_nxt = load_extend(r_rd_ctrl, r_addr[2:0], mem_rsp_rdata);
                            end
                        end
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                    if (!w_discard) begin
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = C_TIMEOUT;
                        w_faddr_nxt = r_addr;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rd_ctrl     <= '0;
            r_wr_ctrl     <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rd_idx      <= '0;
            r_cnt         <= '0;
            r_flushed     <= 1'b0;
            r_done        <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= '0;
            r_fault_addr  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_flushed     <= w_flushed_nxt;
            r_done        <= w_done_nxt;
            r_wb_valid    <= w_wb_nxt;
            r_wb_data     <= w_wb_data_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_cause <= w_cause_nxt;
            r_fault_addr  <= w_faddr_nxt;
            if (w_wb_nxt) begin
                r_wb_rd <= r_rd_idx;
            end
            if (w_latch) begin
                r_rd_ctrl <= dm_rd_ctrl;
                r_wr_ctrl <= dm_wr_ctrl;
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_rd_idx  <= rd_idx;
            end
        end
    end

    // Request fields come straight from the latched access, so they cannot move while waiting for ready.
    assign issue_ready   = w_idle;
    assign busy          = ~w_idle;
    assign mem_req_valid = w_req;
    assign mem_req_we    = w_req & (r_wr_ctrl != 3'b000);
    assign mem_req_addr  = w_req ? {r_addr[63:3], 3'b000} : 64'b0;
    assign mem_req_be    = w_req ? store_be(r_wr_ctrl, r_addr[2:0]) : 8'b0;
    assign mem_req_wdata = w_req ? store_lanes(r_wr_ctrl, r_wdata) : 64'b0;
    assign done          = r_done;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign fault_valid   = r_fault;
    assign fault_cause   = r_fault_cause;
    assign fault_addr    = r_fault_addr;

endmodule
